// File: rtl/csi2_lane_byte_aligner_if.sv
// csi2_lane_byte_aligner_if
// Purpose: groups the lane aligner's stream input and aligned-byte output signals.
// Signals:
//   bits_in[1:0]    2 captured bits per cycle, bits_in[0] earlier in time
//   hs_active       lane is in HS mode
//   byte_out[7:0]   aligned byte
//   byte_valid      one-cycle strobe qualifying byte_out
//   sync_found      one-cycle pulse on sync detection
//   sync_corrected  one-cycle pulse with sync_found when the match was inexact
//   sync_err        one-cycle pulse on hunt timeout
//   locked          high while locked to a byte boundary
// Modports: master drives the stream and observes results; slave is the aligner.
interface csi2_lane_byte_aligner_if;
    logic [1:0] bits_in;
    logic       hs_active;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       sync_found;
    logic       sync_corrected;
    logic       sync_err;
    logic       locked;

    modport master (
        output bits_in,
        output hs_active,
        input  byte_out,
        input  byte_valid,
        input  sync_found,
        input  sync_corrected,
        input  sync_err,
        input  locked
    );

    modport slave (
        input  bits_in,
        input  hs_active,
        output byte_out,
        output byte_valid,
        output sync_found,
        output sync_corrected,
        output sync_err,
        output locked
    );
endinterface

// File: rtl/csi2_lane_byte_aligner.sv
// csi2_lane_byte_aligner
// Purpose: per-lane CSI-2 D-PHY byte aligner. Hunts for the HS sync byte at
// either bit offset in a 2-bit-per-cycle stream, then emits one aligned byte
// every 4 cycles until hs_active drops.
// Ports:
//   clk  byte-clock-domain clock
//   rst  asynchronous active-high reset
//   bus  csi2_lane_byte_aligner_if.slave (stream in, aligned bytes and status out)
// Parameters:
//   HUNT_TIMEOUT  hunt cycles without a match before sync_err
//   SYNC_BYTE     sync pattern, bit 0 received first
// Build option: define CSI2_SYNC_ERR_TOLERANT_EN to accept a sync byte with a
// single bit error (reported through sync_corrected).
module csi2_lane_byte_aligner #(
    parameter int unsigned HUNT_TIMEOUT = 32,
    parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
    input  logic                           clk,
    input  logic                           rst,
    csi2_lane_byte_aligner_if.slave        bus
);

    localparam int unsigned HCNT_W = $clog2(HUNT_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_FAIL   = 2'd3;

    logic [1:0]        r_state,          w_state_nxt;
    logic [9:0]        r_h,              w_h_nxt;
    logic [1:0]        r_cnt,            w_cnt_nxt;
    logic [HCNT_W-1:0] r_hcnt,           w_hcnt_nxt;
    logic              r_off,            w_off_nxt;
    logic [7:0]        r_byte_out,       w_byte_out_nxt;
    logic              r_byte_valid,     w_byte_valid_nxt;
    logic              r_sync_found,     w_sync_found_nxt;
    logic              r_sync_corrected, w_sync_corrected_nxt;
    logic              r_sync_err,       w_sync_err_nxt;
    logic              r_locked,         w_locked_nxt;

    logic [9:0]        w_h_shift;
    logic [7:0]        w_win_a;
    logic [7:0]        w_win_b;
    logic              w_exact_a;
    logic              w_exact_b;
    logic              w_match_a;
    logic              w_match_b;
    logic              w_sel_b;
    logic              w_inexact;
    logic [HCNT_W-1:0] w_hcnt_inc;

    // Newest bits enter at the top; bits_in[0] is older than bits_in[1].
    assign w_h_shift  = {bus.bits_in, r_h[9:2]};
    assign w_win_a    = r_h[9:2];
    assign w_win_b    = r_h[8:1];
    assign w_exact_a  = (w_win_a == SYNC_BYTE);
    assign w_exact_b  = (w_win_b == SYNC_BYTE);
    assign w_hcnt_inc = r_hcnt + HCNT_W'(1);

`ifdef CSI2_SYNC_ERR_TOLERANT_EN
    logic [7:0] w_diff_a;
    logic [7:0] w_diff_b;
    logic       w_sel_exact;

    // A difference with at most one set bit is zero or a power of two.
    assign w_diff_a    = w_win_a ^ SYNC_BYTE;
    assign w_diff_b    = w_win_b ^ SYNC_BYTE;
    assign w_match_a   = ((w_diff_a & (w_diff_a - 8'd1)) == 8'd0);
    assign w_match_b   = ((w_diff_b & (w_diff_b - 8'd1)) == 8'd0);
    assign w_sel_exact = w_sel_b ? w_exact_b : w_exact_a;
    assign w_inexact   = ~w_sel_exact;
`else
    assign w_match_a   = w_exact_a;
    assign w_match_b   = w_exact_b;
    assign w_inexact   = 1'b0;
`endif

    // Offset choice: B unless only A matches, or A is exact while B is not.
    assign w_sel_b = (w_match_a && w_match_b) ? ~(w_exact_a && !w_exact_b) : w_match_b;

    // Next-state and registered-output decode.
    always_comb begin
        w_state_nxt          = r_state;
        w_h_nxt              = r_h;
        w_cnt_nxt            = r_cnt;
        w_hcnt_nxt           = r_hcnt;
        w_off_nxt            = r_off;
        w_byte_out_nxt       = r_byte_out;
        w_byte_valid_nxt     = 1'b0;
        w_sync_found_nxt     = 1'b0;
        w_sync_corrected_nxt = 1'b0;
        w_sync_err_nxt       = 1'b0;
        w_locked_nxt         = 1'b0;

        if (!bus.hs_active) begin
            // Leaving HS drops any partial byte and clears the history.
            w_state_nxt = ST_IDLE;
            w_h_nxt     = '0;
            w_cnt_nxt   = '0;
            w_hcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_HUNT;
                    w_h_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_hcnt_nxt  = '0;
                end
                ST_HUNT: begin
                    w_h_nxt = w_h_shift;
                    if (w_match_a || w_match_b) begin
                        w_off_nxt            = w_sel_b;
                        w_cnt_nxt            = 2'd1;
                        w_state_nxt          = ST_LOCKED;
                        w_sync_found_nxt     = 1'b1;
                        w_sync_corrected_nxt = w_inexact;
                        w_locked_nxt         = 1'b1;
                    end else if (w_hcnt_inc == HCNT_W'(HUNT_TIMEOUT)) begin
                        w_hcnt_nxt     = w_hcnt_inc;
                        w_sync_err_nxt = 1'b1;
                        w_state_nxt    = ST_FAIL;
                    end else begin
                        w_hcnt_nxt = w_hcnt_inc;
                    end
                end
                ST_LOCKED: begin
                    w_h_nxt      = w_h_shift;
                    w_cnt_nxt    = r_cnt + 2'd1;
                    w_locked_nxt = 1'b1;
                    if (r_cnt == 2'd0) begin
                        w_byte_out_nxt   = r_off ? w_win_b : w_win_a;
                        w_byte_valid_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_FAIL;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_h              <= '0;
            r_cnt            <= '0;
            r_hcnt           <= '0;
            r_off            <= 1'b0;
            r_byte_out       <= '0;
            r_byte_valid     <= 1'b0;
            r_sync_found     <= 1'b0;
            r_sync_corrected <= 1'b0;
            r_sync_err       <= 1'b0;
            r_locked         <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_h              <= w_h_nxt;
            r_cnt            <= w_cnt_nxt;
            r_hcnt           <= w_hcnt_nxt;
            r_off            <= w_off_nxt;
            r_byte_out       <= w_byte_out_nxt;
            r_byte_valid     <= w_byte_valid_nxt;
            r_sync_found     <= w_sync_found_nxt;
            r_sync_corrected <= w_sync_corrected_nxt;
            r_sync_err       <= w_sync_err_nxt;
            r_locked         <= w_locked_nxt;
        end
    end

    assign bus.byte_out       = r_byte_out;
    assign bus.byte_valid     = r_byte_valid;
    assign bus.sync_found     = r_sync_found;
    assign bus.sync_corrected = r_sync_corrected;
    assign bus.sync_err       = r_sync_err;
    assign bus.locked         = r_locked;

endmodule

// File: tb/tb_csi2_lane_byte_aligner.sv
// tb_csi2_lane_byte_aligner
// Purpose: self-checking bench for csi2_lane_byte_aligner. Each burst is
// described as a bit stream; a stream-level reference finds the first hunt
// cycle whose window matches the sync byte and derives every expected pulse
// and byte from that cycle number and bit positions.
// Build option: CSI2_SYNC_ERR_TOLERANT_EN selects the tolerant expectations.
module tb_csi2_lane_byte_aligner;

    localparam int unsigned HUNT_TIMEOUT = 32;
    localparam logic [7:0]  SYNC         = 8'hB8;
    localparam int          SLEN         = 1024;

    logic clk = 1'b0;
    logic rst;

    csi2_lane_byte_aligner_if u_if ();

    csi2_lane_byte_aligner #(
        .HUNT_TIMEOUT (HUNT_TIMEOUT),
        .SYNC_BYTE    (SYNC)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;

    bit          g_s [0:SLEN-1];
    int          g_len;
    logic [7:0]  g_obs [$];
    int          g_vcyc [$];
    int          g_found_cnt;
    int          g_corr_cnt;
    int          g_err_cnt;

    // Stream construction: random fill, then explicit bits written from the start.
    function automatic void s_clear();
        for (int i = 0; i < SLEN; i++) g_s[i] = 1'($urandom_range(0, 1));
        g_len = 0;
    endfunction

    function automatic void push_zeros(input int n);
        for (int i = 0; i < n; i++) begin
            g_s[g_len] = 1'b0;
            g_len++;
        end
    endfunction

    function automatic void push_rand_bits(input int n);
        for (int i = 0; i < n; i++) begin
            g_s[g_len] = 1'($urandom_range(0, 1));
            g_len++;
        end
    endfunction

    function automatic void push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            g_s[g_len] = b[i];
            g_len++;
        end
    endfunction

    function automatic bit get_bit(input int i);
        if (i < 0 || i >= SLEN) return 1'b0;
        return g_s[i];
    endfunction

    // Byte whose newest bit is stream bit e; bit 0 is the oldest.
    function automatic logic [7:0] win(input int e);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[j] = get_bit(e - 7 + j);
        return w;
    endfunction

    function automatic int rank(input logic [7:0] w);
        if (w == SYNC) return 2;
`ifdef CSI2_SYNC_ERR_TOLERANT_EN
        if ($countones(w ^ SYNC) == 1) return 1;
`endif
        return 0;
    endfunction

    // One HS burst: hs_active high for hs_len cycles, then two low cycles.
    // rst_at >= 0 asserts reset during that cycle and ends the burst early.
    task automatic run_burst(input string name, input int hs_len, input int rst_at);
        int         k_lock;
        bit         off;
        bit         corr;
        int         ra;
        int         rb;
        int         n;
        int         m;
        bit         live;
        logic [4:0] exp_f;
        logic [4:0] obs_f;
        logic [7:0] exp_b;
        logic [13:0] obs_all;

        k_lock = 0;
        off    = 1'b0;
        corr   = 1'b0;
        g_obs.delete();
        g_vcyc.delete();
        g_found_cnt = 0;
        g_corr_cnt  = 0;
        g_err_cnt   = 0;

        // Hunt cycle k examines the history holding the first 2(k-1) stream bits.
        for (int k = 1; k <= int'(HUNT_TIMEOUT) && k < hs_len; k++) begin
            n  = 2 * (k - 1);
            ra = rank(win(n - 1));
            rb = rank(win(n - 2));
            if (ra > 0 || rb > 0) begin
                k_lock = k;
                off    = (rb > 0 && rb >= ra);
                corr   = off ? (rb == 1) : (ra == 1);
                break;
            end
        end

        for (int c = 0; c < hs_len + 2; c++) begin
            u_if.hs_active = (c < hs_len);
            u_if.bits_in   = {get_bit(2 * c - 1), get_bit(2 * c - 2)};
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1;
                n_vec++;
                obs_all = {u_if.byte_out, u_if.byte_valid, u_if.sync_found,
                           u_if.sync_corrected, u_if.sync_err, u_if.locked, 1'b0};
                if (obs_all !== 14'd0) begin
                    n_err++;
                    $display("FAIL %s async_rst cyc=%0d got=%h exp=0", name, c, obs_all);
                end
                break;
            end
            @(posedge clk);
            #1;
            live  = (c < hs_len);
            exp_f = '0;
            exp_b = '0;
            if (live && k_lock != 0 && c >= k_lock) begin
                exp_f[0] = 1'b1;
                if (c == k_lock) begin
                    exp_f[3] = 1'b1;
                    exp_f[2] = corr;
                end
                if (c > k_lock && ((c - k_lock) % 4) == 0) begin
                    m        = (c - k_lock) / 4;
                    exp_f[4] = 1'b1;
                    exp_b    = win(2 * (k_lock - 1) - 1 - int'(off) + 8 * m);
                end
            end
            if (live && k_lock == 0 && c == int'(HUNT_TIMEOUT)) exp_f[1] = 1'b1;

            obs_f = {u_if.byte_valid, u_if.sync_found, u_if.sync_corrected,
                     u_if.sync_err, u_if.locked};
            if (u_if.byte_valid === 1'b1) begin
                g_obs.push_back(u_if.byte_out);
                g_vcyc.push_back(c);
            end
            if (u_if.sync_found === 1'b1) g_found_cnt++;
            if (u_if.sync_corrected === 1'b1) g_corr_cnt++;
            if (u_if.sync_err === 1'b1) g_err_cnt++;

            n_vec++;
            if (obs_f !== exp_f) begin
                n_err++;
                $display("FAIL %s flags cyc=%0d got vld/fnd/cor/err/lck=%b exp=%b",
                         name, c, obs_f, exp_f);
            end
            if (exp_f[4]) begin
                n_vec++;
                if (u_if.byte_out !== exp_b) begin
                    n_err++;
                    $display("FAIL %s byte cyc=%0d got=%h exp=%h", name, c, u_if.byte_out, exp_b);
                end
            end
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        logic [13:0] obs_all;
        u_if.hs_active = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            u_if.bits_in = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            obs_all = {u_if.byte_out, u_if.byte_valid, u_if.sync_found,
                       u_if.sync_corrected, u_if.sync_err, u_if.locked, 1'b0};
            n_vec++;
            if ({obs_all[5:1]} !== 5'd0) begin
                n_err++;
                $display("FAIL %s idle cyc=%0d got=%h exp=flags 0", name, i, obs_all);
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] obs_all;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_if.hs_active = 1'($urandom_range(0, 1));
            u_if.bits_in   = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            obs_all = {u_if.byte_out, u_if.byte_valid, u_if.sync_found,
                       u_if.sync_corrected, u_if.sync_err, u_if.locked, 1'b0};
            n_vec++;
            if (obs_all !== 14'd0) begin
                n_err++;
                $display("FAIL reset_values cyc=%0d got=%h exp=0", i, obs_all);
            end
        end
        u_if.hs_active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_idle("post_reset", 3);
    endtask

    task automatic test_offset0();
        s_clear();
        push_zeros(8);
        push_byte(SYNC);
        push_byte(8'h12);
        push_byte(8'h34);
        run_burst("offset0", 24, -1);
        n_vec++;
        if (g_obs.size() < 2 || g_obs[0] !== 8'h12 || g_obs[1] !== 8'h34 ||
            g_vcyc[0] != 13 || g_vcyc[1] != 17 || g_found_cnt != 1) begin
            n_err++;
            $display("FAIL offset0_summary got nbytes=%0d found=%0d exp bytes 12,34 at cyc 13,17 found=1",
                     g_obs.size(), g_found_cnt);
        end
    endtask

    task automatic test_offset1();
        s_clear();
        push_zeros(9);
        push_byte(SYNC);
        push_byte(8'h12);
        push_byte(8'h34);
        run_burst("offset1", 24, -1);
        n_vec++;
        if (g_obs.size() < 2 || g_obs[0] !== 8'h12 || g_obs[1] !== 8'h34 ||
            g_vcyc[0] != 14 || g_vcyc[1] != 18 || g_found_cnt != 1) begin
            n_err++;
            $display("FAIL offset1_summary got nbytes=%0d found=%0d exp bytes 12,34 at cyc 14,18 found=1",
                     g_obs.size(), g_found_cnt);
        end
    endtask

    task automatic test_corrupt_sync();
        s_clear();
        push_zeros(8);
        push_byte(8'hB9);
        push_byte(8'h55);
        push_zeros(120);
        run_burst("corrupt", 45, -1);
        n_vec++;
`ifdef CSI2_SYNC_ERR_TOLERANT_EN
        if (g_found_cnt != 1 || g_corr_cnt != 1 || g_obs.size() < 1 || g_obs[0] !== 8'h55) begin
            n_err++;
            $display("FAIL corrupt_tolerant got found=%0d corr=%0d nbytes=%0d exp found=1 corr=1 first=55",
                     g_found_cnt, g_corr_cnt, g_obs.size());
        end
`else
        if (g_found_cnt != 0 || g_err_cnt != 1 || g_obs.size() != 0) begin
            n_err++;
            $display("FAIL corrupt_strict got found=%0d err=%0d nbytes=%0d exp found=0 err=1 nbytes=0",
                     g_found_cnt, g_err_cnt, g_obs.size());
        end
`endif
    endtask

    task automatic test_back_to_back();
        s_clear();
        push_zeros(8);
        push_byte(SYNC);
        push_byte(8'h12);
        push_byte(8'h34);
        push_byte(8'h56);
        run_burst("hs_drop", 19, -1);
        n_vec++;
        if (g_obs.size() != 2) begin
            n_err++;
            $display("FAIL hs_drop_partial got nbytes=%0d exp=2", g_obs.size());
        end
        s_clear();
        push_zeros($urandom_range(0, 9));
        push_byte(SYNC);
        push_rand_bits(64);
        run_burst("relock", 40, -1);
        n_vec++;
        if (g_found_cnt != 1) begin
            n_err++;
            $display("FAIL relock got found=%0d exp=1", g_found_cnt);
        end
    endtask

    task automatic test_rst_locked();
        s_clear();
        push_zeros(8);
        push_byte(SYNC);
        push_byte(8'h12);
        push_byte(8'h34);
        run_burst("rst_mid", 24, 15);
        u_if.hs_active = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_release", 3);
        s_clear();
        push_zeros(3);
        push_byte(SYNC);
        push_byte(8'hA7);
        run_burst("rst_fresh", 20, -1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            s_clear();
            push_rand_bits($urandom_range(0, 40));
            push_byte(SYNC);
            run_burst("random", $urandom_range(12, 60), -1);
        end
    endtask

    initial begin
        rst            = 1'b1;
        u_if.hs_active = 1'b0;
        u_if.bits_in   = 2'b00;
        test_reset();
        test_offset0();
        test_offset1();
        test_corrupt_sync();
        test_back_to_back();
        test_rst_locked();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
